// File: rtl/leaf_pkg.sv
// Shared definitions for the leaf output path: default field widths,
// packet field offsets, the credit maximum and a packed packet view.
package leaf_pkg;

  localparam int DEF_NUM_OUT_PORTS = 2;
  localparam int DEF_PAYLOAD_BITS  = 32;
  localparam int DEF_NUM_LEAF_BITS = 5;
  localparam int DEF_NUM_PORT_BITS = 4;
  localparam int DEF_NUM_ADDR_BITS = 7;

  // Total packet width: valid bit plus leaf, port, addr and payload fields.
  function automatic int packet_bits(int leaf_bits, int port_bits, int addr_bits, int payload_bits);
    return 1 + leaf_bits + port_bits + addr_bits + payload_bits;
  endfunction

  // Payload sits at bit 0; the address field is directly above it.
  function automatic int addr_lsb(int payload_bits);
    return payload_bits;
  endfunction

  // Destination port field sits above the address field.
  function automatic int port_lsb(int addr_bits, int payload_bits);
    return payload_bits + addr_bits;
  endfunction

  // Destination leaf field sits above the port field.
  function automatic int leaf_lsb(int port_bits, int addr_bits, int payload_bits);
    return payload_bits + addr_bits + port_bits;
  endfunction

  // A port may have at most one full destination BRAM of words in flight.
  function automatic int credit_max(int addr_bits);
    return 1 << addr_bits;
  endfunction

  // Port index width, kept at least one bit for single-port builds.
  function automatic int port_idx_bits(int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

  localparam int DEF_PACKET_BITS = packet_bits(DEF_NUM_LEAF_BITS, DEF_NUM_PORT_BITS,
                                               DEF_NUM_ADDR_BITS, DEF_PAYLOAD_BITS);

  // Packet layout at the default widths, valid at the MSB.
  typedef struct packed {
    logic                         valid;
    logic [DEF_NUM_LEAF_BITS-1:0] leaf;
    logic [DEF_NUM_PORT_BITS-1:0] port;
    logic [DEF_NUM_ADDR_BITS-1:0] addr;
    logic [DEF_PAYLOAD_BITS-1:0]  payload;
  } leaf_packet_t;

endpackage

// File: rtl/leaf_out_arbiter_if.sv
// User word handshake and network-facing packet bus of the leaf output arbiter.
interface leaf_out_arbiter_if #(
  parameter int NUM_OUT_PORTS = leaf_pkg::DEF_NUM_OUT_PORTS,
  parameter int PAYLOAD_BITS  = leaf_pkg::DEF_PAYLOAD_BITS,
  parameter int PACKET_BITS   = leaf_pkg::DEF_PACKET_BITS
);

  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
  logic [NUM_OUT_PORTS-1:0]              vld_user2interface;
  logic [NUM_OUT_PORTS-1:0]              ack_interface2user;
  logic                                  bft_ready;
  logic [PACKET_BITS-1:0]                dout_leaf_interface2bft;

  modport master (
    output din_leaf_user2interface,
    output vld_user2interface,
    output bft_ready,
    input  ack_interface2user,
    input  dout_leaf_interface2bft
  );

  modport slave (
    input  din_leaf_user2interface,
    input  vld_user2interface,
    input  bft_ready,
    output ack_interface2user,
    output dout_leaf_interface2bft
  );

endinterface

// File: rtl/leaf_fifo2.sv
// Two-entry FIFO buffering one user port; push and pop may coincide even when full.
module leaf_fifo2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Round-robin arbiter merging per-port user words into addressed network
// packets, with per-port destination table, credit flow control and rewind.
module leaf_out_arbiter
  import leaf_pkg::*;
#(
  parameter int NUM_OUT_PORTS = DEF_NUM_OUT_PORTS,
  parameter int PAYLOAD_BITS  = DEF_PAYLOAD_BITS,
  parameter int NUM_LEAF_BITS = DEF_NUM_LEAF_BITS,
  parameter int NUM_PORT_BITS = DEF_NUM_PORT_BITS,
  parameter int NUM_ADDR_BITS = DEF_NUM_ADDR_BITS,
  parameter int PACKET_BITS   = packet_bits(NUM_LEAF_BITS, NUM_PORT_BITS, NUM_ADDR_BITS, PAYLOAD_BITS)
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  leaf_out_arbiter_if.slave                        bus,
  input  logic                                     cfg_we,
  input  logic [port_idx_bits(NUM_OUT_PORTS)-1:0]  cfg_port,
  input  logic [NUM_LEAF_BITS+NUM_PORT_BITS-1:0]   cfg_dest,
  input  logic                                     credit_vld,
  input  logic [port_idx_bits(NUM_OUT_PORTS)-1:0]  credit_port,
  input  logic [NUM_ADDR_BITS:0]                   credit_cnt,
  input  logic                                     resend
);

  localparam int PIB         = port_idx_bits(NUM_OUT_PORTS);
  localparam int DEST_BITS   = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam int CREDIT_BITS = NUM_ADDR_BITS + 1;
  localparam int SUM_BITS    = NUM_ADDR_BITS + 2;
  localparam int VALID_BIT   = PACKET_BITS - 1;
  localparam int ADDR_LSB    = addr_lsb(PAYLOAD_BITS);
  localparam int DEST_LSB    = port_lsb(NUM_ADDR_BITS, PAYLOAD_BITS);
  localparam logic [CREDIT_BITS-1:0] CREDIT_MAX = CREDIT_BITS'(credit_max(NUM_ADDR_BITS));

  logic [PAYLOAD_BITS-1:0]  fifo_head  [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] fifo_full;
  logic [NUM_OUT_PORTS-1:0] fifo_empty;
  logic [NUM_OUT_PORTS-1:0] push;
  logic [NUM_OUT_PORTS-1:0] pop;
  logic [NUM_OUT_PORTS-1:0] eligible;

  logic [DEST_BITS-1:0]     dest_q     [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] configured_q;
  logic [CREDIT_BITS-1:0]   credit_q   [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   credit_nxt [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr_q     [NUM_OUT_PORTS];
  logic [SUM_BITS-1:0]      credit_sum;

  logic [PIB-1:0]           last_grant_q;
  logic [PIB-1:0]           grant_port;
  logic [PIB-1:0]           cand;
  int                       cand_int;
  logic                     found;
  logic                     grant;
  logic [PACKET_BITS-1:0]   dout_q;
  logic [PACKET_BITS-1:0]   load_pkt;

  assign push                        = bus.vld_user2interface & ~fifo_full;
  assign bus.ack_interface2user      = ~fifo_full;
  assign bus.dout_leaf_interface2bft = dout_q;

  for (genvar g = 0; g < NUM_OUT_PORTS; g++) begin : g_port
    leaf_fifo2 #(.WIDTH(PAYLOAD_BITS)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push[g]),
      .din     (bus.din_leaf_user2interface[g*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .pop     (pop[g]),
      .head    (fifo_head[g]),
      .full    (fifo_full[g]),
      .empty   (fifo_empty[g])
    );
    assign eligible[g] = !fifo_empty[g] && configured_q[g] && (credit_q[g] != '0);
    assign pop[g]      = grant && (grant_port == PIB'(g));
  end

  // Round-robin search starting just after the last granted port.
  always_comb begin
    grant_port = last_grant_q;
    found      = 1'b0;
    cand_int   = 0;
    cand       = '0;
    for (int k = 1; k <= NUM_OUT_PORTS; k++) begin
      cand_int = int'(last_grant_q) + k;
      if (cand_int >= NUM_OUT_PORTS) begin
        cand_int = cand_int - NUM_OUT_PORTS;
      end
      cand = cand_int[PIB-1:0];
      if (!found && eligible[cand]) begin
        found      = 1'b1;
        grant_port = cand;
      end
    end
    grant = (!dout_q[VALID_BIT] || bus.bft_ready) && !resend && found;
  end

  // Assemble the packet for the granted port from its table entry, address and head word.
  always_comb begin
    load_pkt                                 = '0;
    load_pkt[VALID_BIT]                      = 1'b1;
    load_pkt[DEST_LSB +: DEST_BITS]          = dest_q[grant_port];
    load_pkt[ADDR_LSB +: NUM_ADDR_BITS]      = addr_q[grant_port];
    load_pkt[0 +: PAYLOAD_BITS]              = fifo_head[grant_port];
  end

  // Net credit change per port: returned credit minus one per grant, saturated at the maximum.
  always_comb begin
    credit_sum = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      credit_sum = SUM_BITS'(credit_q[i]);
      if (credit_vld && (credit_port == PIB'(i))) begin
        credit_sum = credit_sum + SUM_BITS'(credit_cnt);
      end
      if (pop[i]) begin
        credit_sum = credit_sum - SUM_BITS'(1);
      end
      credit_nxt[i] = (credit_sum > SUM_BITS'(CREDIT_MAX)) ? CREDIT_MAX : credit_sum[CREDIT_BITS-1:0];
    end
  end

  // Destination table writes; a written entry stays configured until reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      configured_q <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        dest_q[i] <= '0;
      end
    end else if (cfg_we) begin
      dest_q[cfg_port]       <= cfg_dest;
      configured_q[cfg_port] <= 1'b1;
    end
  end

  // Credit and address counters; a rewind restarts every destination buffer from empty.
  always_ff @(posedge clk) begin
    if (!reset_n || resend) begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit_q[i] <= CREDIT_MAX;
        addr_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit_q[i] <= credit_nxt[i];
        if (pop[i]) begin
          addr_q[i] <= addr_q[i] + 1'b1;
        end
      end
    end
  end

  // Output register and round-robin pointer; the packet holds while the network stalls.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dout_q       <= '0;
      last_grant_q <= PIB'(NUM_OUT_PORTS - 1);
    end else if (resend) begin
      dout_q[VALID_BIT] <= 1'b0;
    end else if (grant) begin
      dout_q       <= load_pkt;
      last_grant_q <= grant_port;
    end else if (bus.bft_ready) begin
      dout_q[VALID_BIT] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Self-checking bench for leaf_out_arbiter: a negedge monitor scores every
// packet taken by the network against per-port queues of accepted words.
module tb_leaf_out_arbiter;
  import leaf_pkg::*;

  localparam int N   = 2;
  localparam int PB  = 32;
  localparam int LB  = 5;
  localparam int PTB = 4;
  localparam int AB  = 7;
  localparam int DB  = LB + PTB;
  localparam int KB  = 1 + DB + AB + PB;
  localparam logic [DB-1:0] DEST0 = {5'd3, 4'd2};
  localparam logic [DB-1:0] DEST1 = {5'd7, 4'd9};

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cfg_we;
  logic [0:0]    cfg_port;
  logic [DB-1:0] cfg_dest;
  logic          credit_vld;
  logic [0:0]    credit_port;
  logic [AB:0]   credit_cnt;
  logic          resend;

  int total = 0;
  int bad = 0;
  int emit_cnt = 0;
  int accept_cnt = 0;
  int word_seq = 0;
  logic [AB-1:0] last_addr;
  logic [PB-1:0] q0[$];
  logic [PB-1:0] q1[$];
  logic [AB-1:0] exp_addr [N];
  int port_log[$];
  logic [KB-1:0] snap_q[$];

  always #5 clk = ~clk;

  leaf_out_arbiter_if #(.NUM_OUT_PORTS(N), .PAYLOAD_BITS(PB), .PACKET_BITS(KB)) bus ();

  leaf_out_arbiter #(
    .NUM_OUT_PORTS(N), .PAYLOAD_BITS(PB), .NUM_LEAF_BITS(LB),
    .NUM_PORT_BITS(PTB), .NUM_ADDR_BITS(AB), .PACKET_BITS(KB)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .cfg_we      (cfg_we),
    .cfg_port    (cfg_port),
    .cfg_dest    (cfg_dest),
    .credit_vld  (credit_vld),
    .credit_port (credit_port),
    .credit_cnt  (credit_cnt),
    .resend      (resend)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_monitor();
    logic [KB-1:0] pkt;
    logic [DB-1:0] dest;
    logic [PB-1:0] expw;
    int p;
    forever begin
      @(negedge clk);
      pkt = bus.dout_leaf_interface2bft;
      if (reset_n !== 1'b1) begin
        q0.delete();
        q1.delete();
        exp_addr[0] = '0;
        exp_addr[1] = '0;
      end else begin
        if (pkt[KB-1] === 1'b1 && bus.bft_ready === 1'b1) begin
          dest = pkt[PB+AB +: DB];
          p = (dest === DEST0) ? 0 : ((dest === DEST1) ? 1 : -1);
          total++;
          if (p < 0) begin
            bad++;
            $display("[TB] FAIL mon_dest: got %h, required %h or %h", dest, DEST0, DEST1);
          end else begin
            emit_cnt++;
            last_addr = pkt[PB +: AB];
            port_log.push_back(p);
            if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
              bad++;
              $display("[TB] FAIL mon_unexpected: port %0d emitted %h, required no packet", p, pkt[PB-1:0]);
            end else begin
              expw = (p == 0) ? q0.pop_front() : q1.pop_front();
              if (pkt[PB-1:0] !== expw) begin
                bad++;
                $display("[TB] FAIL mon_payload: port %0d got %h, required %h", p, pkt[PB-1:0], expw);
              end
            end
            total++;
            if (pkt[PB +: AB] !== exp_addr[p]) begin
              bad++;
              $display("[TB] FAIL mon_addr: port %0d got %0d, required %0d", p, pkt[PB +: AB], exp_addr[p]);
            end
            exp_addr[p] = exp_addr[p] + 1'b1;
          end
        end
        if (resend === 1'b1) begin
          exp_addr[0] = '0;
          exp_addr[1] = '0;
        end
        if (bus.vld_user2interface[0] && bus.ack_interface2user[0]) q0.push_back(bus.din_leaf_user2interface[0 +: PB]);
        if (bus.vld_user2interface[1] && bus.ack_interface2user[1]) q1.push_back(bus.din_leaf_user2interface[PB +: PB]);
      end
    end
  endtask

  task automatic do_reset();
    bus.vld_user2interface = '0;
    bus.bft_ready = 1'b1;
    cfg_we = 1'b0;
    credit_vld = 1'b0;
    resend = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic configure(input int p, input logic [DB-1:0] d);
    cfg_we = 1'b1;
    cfg_port = p[0:0];
    cfg_dest = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic new_word(input int p);
    word_seq++;
    bus.din_leaf_user2interface[p*PB +: PB] = 32'h1000_0000 * (p + 1) + word_seq;
  endtask

  // Streams fresh words on the enabled ports; resend pulses on edge index resend_at.
  task automatic stream(input logic [N-1:0] en, input int cycles, input int resend_at);
    logic [N-1:0] acc;
    snap_q.delete();
    for (int p = 0; p < N; p++) new_word(p);
    for (int c = 0; c < cycles; c++) begin
      bus.vld_user2interface = en;
      resend = (c == resend_at);
      @(negedge clk);
      acc = bus.vld_user2interface & bus.ack_interface2user;
      tick();
      snap_q.push_back(bus.dout_leaf_interface2bft);
      for (int p = 0; p < N; p++) begin
        if (acc[p]) begin
          accept_cnt++;
          new_word(p);
        end
      end
    end
    bus.vld_user2interface = '0;
    resend = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    total++;
    if (bus.dout_leaf_interface2bft !== '0) begin
      bad++;
      $display("[TB] FAIL reset_dout: got %h, required 0", bus.dout_leaf_interface2bft);
    end
    reset_n = 1'b1;
    tick();
    total++;
    if (bus.ack_interface2user !== 2'b11) begin
      bad++;
      $display("[TB] FAIL reset_ack: got %b, required 11", bus.ack_interface2user);
    end
    total++;
    if (bus.dout_leaf_interface2bft !== '0) begin
      bad++;
      $display("[TB] FAIL reset_dout_idle: got %h, required 0", bus.dout_leaf_interface2bft);
    end
  endtask

  task automatic test_latency();
    leaf_packet_t exp_pkt;
    exp_pkt = '{valid: 1'b1, leaf: 5'd3, port: 4'd2, addr: 7'd0, payload: 32'hA5A5_A5A5};
    configure(0, DEST0);
    bus.din_leaf_user2interface[0 +: PB] = 32'hA5A5_A5A5;
    bus.vld_user2interface = 2'b01;
    tick();
    bus.vld_user2interface = 2'b00;
    total++;
    if (bus.dout_leaf_interface2bft[KB-1] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL latency_early: valid got %b, required 0", bus.dout_leaf_interface2bft[KB-1]);
    end
    tick();
    total++;
    if (bus.dout_leaf_interface2bft !== exp_pkt) begin
      bad++;
      $display("[TB] FAIL latency_pkt: got %h, required %h", bus.dout_leaf_interface2bft, exp_pkt);
    end
    repeat (3) tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    configure(0, DEST0);
    configure(1, DEST1);
    port_log.delete();
    stream(2'b11, 14, -1);
    repeat (8) tick();
    total++;
    if (port_log.size() < 8) begin
      bad++;
      $display("[TB] FAIL rr_count: got %0d grants, required at least 8", port_log.size());
    end else begin
      total++;
      if (port_log[0] !== 0) begin
        bad++;
        $display("[TB] FAIL rr_first: got port %0d, required port 0", port_log[0]);
      end
      for (int i = 1; i < 8; i++) begin
        total++;
        if (port_log[i] === port_log[i-1]) begin
          bad++;
          $display("[TB] FAIL rr_alternate: grant %0d got port %0d, required port %0d", i, port_log[i], 1 - port_log[i-1]);
        end
      end
    end
  endtask

  task automatic test_credit();
    do_reset();
    configure(0, DEST0);
    credit_vld = 1'b1;
    credit_port = 1'b0;
    credit_cnt = 8'd50;
    tick();
    credit_vld = 1'b0;
    emit_cnt = 0;
    accept_cnt = 0;
    stream(2'b01, 160, -1);
    total++;
    if (emit_cnt !== 128) begin
      bad++;
      $display("[TB] FAIL credit_exhaust: got %0d packets, required 128", emit_cnt);
    end
    total++;
    if (accept_cnt !== 130) begin
      bad++;
      $display("[TB] FAIL credit_accepted: got %0d words, required 130", accept_cnt);
    end
    total++;
    if (bus.ack_interface2user[0] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL credit_ack_full: got %b, required 0", bus.ack_interface2user[0]);
    end
    credit_vld = 1'b1;
    credit_cnt = 8'd1;
    tick();
    credit_vld = 1'b0;
    repeat (6) tick();
    total++;
    if (emit_cnt !== 129) begin
      bad++;
      $display("[TB] FAIL credit_return: got %0d packets, required 129", emit_cnt);
    end
    total++;
    if (last_addr !== 7'd0) begin
      bad++;
      $display("[TB] FAIL credit_wrap_addr: got %0d, required 0", last_addr);
    end
    total++;
    if (bus.ack_interface2user[0] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL credit_ack_free: got %b, required 1", bus.ack_interface2user[0]);
    end
  endtask

  task automatic test_stall();
    logic [KB-1:0] held;
    int waited;
    do_reset();
    configure(0, DEST0);
    bus.din_leaf_user2interface[0 +: PB] = 32'hCAFE_0001;
    bus.vld_user2interface = 2'b01;
    tick();
    bus.vld_user2interface = 2'b00;
    waited = 0;
    while (bus.dout_leaf_interface2bft[KB-1] !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    total++;
    if (bus.dout_leaf_interface2bft[KB-1] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL stall_timeout: valid got %b, required 1 within 10 cycles", bus.dout_leaf_interface2bft[KB-1]);
    end
    bus.bft_ready = 1'b0;
    held = bus.dout_leaf_interface2bft;
    for (int c = 0; c < 5; c++) begin
      if (c < 2) begin
        bus.din_leaf_user2interface[0 +: PB] = 32'hCAFE_0002 + c;
        bus.vld_user2interface = 2'b01;
      end else begin
        bus.vld_user2interface = 2'b00;
      end
      tick();
      total++;
      if (bus.dout_leaf_interface2bft !== held) begin
        bad++;
        $display("[TB] FAIL stall_hold: cycle %0d got %h, required %h", c, bus.dout_leaf_interface2bft, held);
      end
    end
    total++;
    if (bus.ack_interface2user[0] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stall_ack: got %b, required 0", bus.ack_interface2user[0]);
    end
    bus.bft_ready = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_resend();
    int idx;
    do_reset();
    configure(0, DEST0);
    stream(2'b01, 12, 6);
    repeat (8) tick();
    total++;
    if (snap_q[6][KB-1] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL resend_valid: got %b, required 0", snap_q[6][KB-1]);
    end
    idx = 7;
    while (idx < snap_q.size() && snap_q[idx][KB-1] !== 1'b1) idx++;
    total++;
    if (idx >= snap_q.size()) begin
      bad++;
      $display("[TB] FAIL resend_next: got no packet after rewind, required one");
    end else if (snap_q[idx][PB +: AB] !== 7'd0) begin
      bad++;
      $display("[TB] FAIL resend_addr: got %0d, required 0", snap_q[idx][PB +: AB]);
    end
  endtask

  task automatic test_reset_midstream();
    int seen;
    do_reset();
    configure(0, DEST0);
    configure(1, DEST1);
    stream(2'b11, 6, -1);
    bus.vld_user2interface = 2'b11;
    reset_n = 1'b0;
    tick();
    total++;
    if (bus.dout_leaf_interface2bft !== '0) begin
      bad++;
      $display("[TB] FAIL midreset_dout: got %h, required 0", bus.dout_leaf_interface2bft);
    end
    reset_n = 1'b1;
    bus.vld_user2interface = 2'b00;
    tick();
    total++;
    if (bus.ack_interface2user !== 2'b11) begin
      bad++;
      $display("[TB] FAIL midreset_ack: got %b, required 11", bus.ack_interface2user);
    end
    configure(0, DEST0);
    configure(1, DEST1);
    seen = 0;
    repeat (12) begin
      tick();
      if (bus.dout_leaf_interface2bft[KB-1] === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("[TB] FAIL midreset_stale: got %0d valid cycles, required 0", seen);
    end
  endtask

  task automatic test_drained();
    total++;
    if (q0.size() !== 0) begin
      bad++;
      $display("[TB] FAIL drain_port0: got %0d words left, required 0", q0.size());
    end
    total++;
    if (q1.size() !== 0) begin
      bad++;
      $display("[TB] FAIL drain_port1: got %0d words left, required 0", q1.size());
    end
  endtask

  initial begin
    reset_n = 1'b0;
    bus.din_leaf_user2interface = '0;
    bus.vld_user2interface = '0;
    bus.bft_ready = 1'b1;
    cfg_we = 1'b0;
    cfg_port = '0;
    cfg_dest = '0;
    credit_vld = 1'b0;
    credit_port = '0;
    credit_cnt = '0;
    resend = 1'b0;
    fork
      run_monitor();
    join_none
    $display("[TB] starting leaf_out_arbiter bench");
    test_reset();
    test_latency();
    test_round_robin();
    test_credit();
    test_stall();
    test_resend();
    test_reset_midstream();
    test_drained();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
